// File: rtl/bch_correct_buffer_pkg.sv
// Shared types and sizing helpers for the BCH correction buffer.
package bch_correct_buffer_pkg;

  typedef enum logic {WR_IDLE = 1'b0, WR_FILL = 1'b1} wr_state_e;
  typedef enum logic {RD_IDLE = 1'b0, RD_RUN = 1'b1} rd_state_e;

  function automatic int bch_clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  function automatic int bch_beats(input int data_bits, input int bits);
    return (data_bits + bits - 1) / bits;
  endfunction

  function automatic int bch_max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/bch_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module bch_buffer_ram #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 20,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bch_correct_buffer.sv
// Final BCH stage: buffers codeword data bits and replays them XORed with the
// error-mask stream, two cycles after each err beat.
module bch_correct_buffer
  import bch_correct_buffer_pkg::*;
#(
  parameter int DATA_BITS = 5,
  parameter int BITS      = 1,
  parameter int DEPTH     = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ce_in,
  input  logic                              start_in,
  input  logic [BITS-1:0]                   data_in,
  input  logic                              err_first,
  input  logic [BITS-1:0]                   err,
  output logic [BITS-1:0]                   data_out,
  output logic                              valid_out,
  output logic                              first_out,
  output logic                              last_out,
  output logic [bch_clog2(DEPTH+1)-1:0]     pending,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int BEATS  = bch_beats(DATA_BITS, BITS);
  localparam int SLOT_W = bch_max1(bch_clog2(DEPTH));
  localparam int BEAT_W = bch_max1(bch_clog2(BEATS));
  localparam int WORDS  = DEPTH * BEATS;
  localparam int ADDR_W = bch_max1(bch_clog2(WORDS));
  localparam int CNT_W  = bch_clog2(DEPTH + 1);
  localparam int REM    = DATA_BITS % BITS;
  localparam logic [BITS-1:0] LAST_MASK = (REM == 0) ? {BITS{1'b1}} : BITS'((1 << REM) - 1);

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W-1:0] slot,
                                                  input logic [BEAT_W-1:0] beat);
    return ADDR_W'(slot) * ADDR_W'(BEATS) + ADDR_W'(beat);
  endfunction

  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic [SLOT_W-1:0] wslot_q, wslot_d, rslot_q, rslot_d, wslot_inc, rslot_inc, start_slot;
  logic [BEAT_W-1:0] wbeat_q, wbeat_d, rbeat_q, rbeat_d;
  logic [CNT_W-1:0]  pending_q, pending_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              we, re, wr_done, consume, rd_first, rd_last, full, have_cw;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [BITS-1:0]   ram_rdata;

  assign wslot_inc = wslot_q + SLOT_W'(1);
  assign rslot_inc = rslot_q + SLOT_W'(1);

  always_comb begin
    rd_state_d = rd_state_q;
    rslot_d    = rslot_q;
    rbeat_d    = rbeat_q;
    unf_d      = unf_q;
    re         = 1'b0;
    raddr      = slot_addr(rslot_q, '0);
    rd_first   = 1'b0;
    rd_last    = 1'b0;
    consume    = 1'b0;
    start_slot = rslot_q;
    have_cw    = 1'b0;
    if (err_first) begin
      // A new err_first mid-codeword retires the one in progress before starting.
      if (rd_state_q == RD_RUN) begin
        consume    = 1'b1;
        start_slot = rslot_inc;
        have_cw    = pending_q > CNT_W'(1);
      end else begin
        have_cw    = pending_q != '0;
      end
      rslot_d = start_slot;
      if (have_cw) begin
        re       = 1'b1;
        raddr    = slot_addr(start_slot, '0);
        rd_first = 1'b1;
        rd_last  = (BEATS == 1);
        if (BEATS == 1) begin
          consume    = 1'b1;
          rslot_d    = rslot_inc;
          rd_state_d = RD_IDLE;
        end else begin
          rd_state_d = RD_RUN;
          rbeat_d    = BEAT_W'(1);
        end
      end else begin
        unf_d      = 1'b1;
        rd_state_d = RD_IDLE;
      end
    end else if (rd_state_q == RD_RUN) begin
      re      = 1'b1;
      raddr   = slot_addr(rslot_q, rbeat_q);
      rd_last = rbeat_q == BEAT_W'(BEATS - 1);
      if (rd_last) begin
        consume    = 1'b1;
        rslot_d    = rslot_inc;
        rd_state_d = RD_IDLE;
      end else begin
        rbeat_d = rbeat_q + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wslot_d    = wslot_q;
    wbeat_d    = wbeat_q;
    ovf_d      = ovf_q;
    we         = 1'b0;
    waddr      = slot_addr(wslot_q, '0);
    wr_done    = 1'b0;
    full       = (pending_q == CNT_W'(DEPTH)) && !consume;
    if (ce_in) begin
      // A restart while filling reuses the same slot, so no full check is needed.
      if (start_in && (wr_state_q == WR_FILL || !full)) begin
        we = 1'b1;
        if (BEATS == 1) begin
          wr_done = 1'b1;
          wslot_d = wslot_inc;
        end else begin
          wr_state_d = WR_FILL;
          wbeat_d    = BEAT_W'(1);
        end
      end else if (start_in) begin
        ovf_d = 1'b1;
      end else if (wr_state_q == WR_FILL) begin
        we    = 1'b1;
        waddr = slot_addr(wslot_q, wbeat_q);
        if (wbeat_q == BEAT_W'(BEATS - 1)) begin
          wr_done    = 1'b1;
          wslot_d    = wslot_inc;
          wr_state_d = WR_IDLE;
        end else begin
          wbeat_d = wbeat_q + BEAT_W'(1);
        end
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (wr_done && !consume) pending_d = pending_q + CNT_W'(1);
    else if (consume && !wr_done) pending_d = pending_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      wslot_q    <= '0;
      rslot_q    <= '0;
      wbeat_q    <= '0;
      rbeat_q    <= '0;
      pending_q  <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wslot_q    <= wslot_d;
      rslot_q    <= rslot_d;
      wbeat_q    <= wbeat_d;
      rbeat_q    <= rbeat_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  bch_buffer_ram #(.WIDTH(BITS), .DEPTH(WORDS), .AW(ADDR_W)) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(data_in),
    .re_i   (re),
    .raddr_i(raddr),
    .rdata_o(ram_rdata)
  );

  // Stage p1: RAM read in flight, err delayed to line up with it.
  logic [BITS-1:0] err_p1_q;
  logic            vld_p1_q, first_p1_q, last_p1_q;

  always_ff @(posedge clk) err_p1_q <= err;

  // Stage p2: corrected beat registered to the outputs.
  logic [BITS-1:0] data_out_q, data_out_d;
  logic            valid_out_q, first_out_q, last_out_q;

  assign data_out_d = vld_p1_q ? ((ram_rdata ^ err_p1_q) & (last_p1_q ? LAST_MASK : {BITS{1'b1}}))
                               : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      first_p1_q  <= 1'b0;
      last_p1_q   <= 1'b0;
      valid_out_q <= 1'b0;
      first_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      data_out_q  <= '0;
    end else begin
      vld_p1_q    <= re;
      first_p1_q  <= rd_first;
      last_p1_q   <= rd_last;
      valid_out_q <= vld_p1_q;
      first_out_q <= vld_p1_q & first_p1_q;
      last_out_q  <= vld_p1_q & last_p1_q;
      data_out_q  <= data_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign first_out = first_out_q;
  assign last_out  = last_out_q;
  assign pending   = pending_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_bch_correct_buffer.sv
// Bench for bch_correct_buffer: vector tables, corner sequences and a
// queue-based reference model driven by random stimulus.
module tb_bch_correct_buffer;

  localparam int NB = 5;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       ce_in = 0, start_in = 0, err_first = 0;
  logic [0:0] data_in = '0, err = '0, data_out;
  logic       valid_out, first_out, last_out, overflow, underflow;
  logic [2:0] pending;

  logic       b_ce = 0, b_st = 0, b_ef = 0;
  logic [3:0] b_d = '0, b_e = '0, b_do;
  logic       b_vo, b_fo, b_lo, b_ovf, b_unf;
  logic [2:0] b_pend;

  bch_correct_buffer #(.DATA_BITS(5), .BITS(1), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ce_in(ce_in), .start_in(start_in), .data_in(data_in),
    .err_first(err_first), .err(err), .data_out(data_out), .valid_out(valid_out),
    .first_out(first_out), .last_out(last_out), .pending(pending),
    .overflow(overflow), .underflow(underflow));

  bch_correct_buffer #(.DATA_BITS(7), .BITS(4), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ce_in(b_ce), .start_in(b_st), .data_in(b_d),
    .err_first(b_ef), .err(b_e), .data_out(b_do), .valid_out(b_vo),
    .first_out(b_fo), .last_out(b_lo), .pending(b_pend),
    .overflow(b_ovf), .underflow(b_unf));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic       ce, st;
    logic [3:0] d;
    logic       ef;
    logic [3:0] e;
    logic       v, f, l;
    logic [3:0] dout;
    int         pend;
  } vec_t;

  function automatic vec_t mk(input logic ce, st, input logic [3:0] d, input logic ef,
                              input logic [3:0] e, input logic v, f, l,
                              input logic [3:0] dout, input int pend);
    vec_t r;
    r.ce = ce; r.st = st; r.d = d; r.ef = ef; r.e = e;
    r.v = v; r.f = f; r.l = l; r.dout = dout; r.pend = pend;
    return r;
  endfunction

  // Reference model: queue of complete codewords, bit b = beat b.
  typedef struct packed {logic v, f, l, d;} out_t;
  logic [NB-1:0] mq[$];
  logic [NB-1:0] part;
  int            pidx, ridx;
  bit            filling, rd_act, m_ovf, m_unf;
  out_t          exp_prev;

  task automatic model_reset();
    mq.delete();
    part = '0; pidx = 0; ridx = 0;
    filling = 0; rd_act = 0; m_ovf = 0; m_unf = 0;
    exp_prev = '0;
  endtask

  task automatic model_step(input logic ce, st, d, ef, e, output out_t o);
    bit consume = 0;
    bit done = 0;
    int base;
    o = '0;
    if (ef) begin
      base = rd_act ? 1 : 0;
      consume = rd_act;
      if (mq.size() - base > 0) begin
        o.v = 1; o.f = 1; o.l = (NB == 1); o.d = mq[base][0] ^ e;
        rd_act = 1; ridx = 1;
      end else begin
        m_unf = 1; rd_act = 0;
      end
    end else if (rd_act) begin
      o.v = 1; o.d = mq[0][ridx] ^ e; o.l = (ridx == NB - 1);
      if (o.l) begin consume = 1; rd_act = 0; end
      ridx++;
    end
    if (ce) begin
      if (st) begin
        if (!filling && (mq.size() - int'(consume)) == DP) m_ovf = 1;
        else begin filling = 1; part = '0; part[0] = d; pidx = 1; end
      end else if (filling) begin
        part[pidx] = d; pidx++;
      end
      if (filling && pidx == NB) begin done = 1; filling = 0; end
    end
    if (consume) void'(mq.pop_front());
    if (done) mq.push_back(part);
  endtask

  task automatic mcyc(input logic ce, st, d, ef, e);
    out_t o;
    ce_in = ce; start_in = st; data_in = d; err_first = ef; err = e;
    @(posedge clk);
    model_step(ce, st, d, ef, e, o);
    #1;
    chk("valid_out", valid_out, exp_prev.v);
    chk("first_out", first_out, exp_prev.f);
    chk("last_out", last_out, exp_prev.l);
    chk("data_out", data_out, exp_prev.d);
    chk("pending", pending, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    exp_prev = o;
  endtask

  task automatic do_reset();
    ce_in = 0; start_in = 0; data_in = '0; err_first = 0; err = '0;
    b_ce = 0; b_st = 0; b_d = '0; b_ef = 0; b_e = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst valid_out", valid_out, 0);
    chk("rst data_out", data_out, 0);
    chk("rst pending", pending, 0);
    chk("rst flags", {overflow, underflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl_a[12];
  vec_t tbl_b[10];

  initial begin
    tbl_a[0]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl_a[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl_a[2]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl_a[3]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl_a[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl_a[5]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    tbl_a[6]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    tbl_a[7]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    tbl_a[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl_a[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tbl_a[10] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    tbl_a[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl_b[0] = mk(1, 1, 4'h5, 0, 4'h0, 0, 0, 0, 4'h0, 0);
    tbl_b[1] = mk(1, 0, 4'h3, 0, 4'h0, 0, 0, 0, 4'h0, 1);
    tbl_b[2] = mk(1, 1, 4'hF, 0, 4'h0, 0, 0, 0, 4'h0, 1);
    tbl_b[3] = mk(1, 0, 4'hF, 0, 4'h0, 0, 0, 0, 4'h0, 2);
    tbl_b[4] = mk(0, 0, 4'h0, 1, 4'h0, 0, 0, 0, 4'h0, 2);
    tbl_b[5] = mk(0, 0, 4'h0, 0, 4'h1, 1, 1, 0, 4'h5, 1);
    tbl_b[6] = mk(0, 0, 4'h0, 1, 4'h0, 1, 0, 1, 4'h2, 1);
    tbl_b[7] = mk(0, 0, 4'h0, 0, 4'h0, 1, 1, 0, 4'hF, 0);
    tbl_b[8] = mk(0, 0, 4'h0, 0, 4'h0, 1, 0, 1, 4'h7, 0);
    tbl_b[9] = mk(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0);

    do_reset();

    for (int i = 0; i < 12; i++) begin
      ce_in = tbl_a[i].ce; start_in = tbl_a[i].st; data_in = tbl_a[i].d[0];
      err_first = tbl_a[i].ef; err = tbl_a[i].e[0];
      @(posedge clk); #1;
      chk("tblA valid", valid_out, tbl_a[i].v);
      chk("tblA first", first_out, tbl_a[i].f);
      chk("tblA last", last_out, tbl_a[i].l);
      chk("tblA data", data_out, tbl_a[i].dout[0]);
      chk("tblA pending", pending, tbl_a[i].pend);
    end
    ce_in = 0; start_in = 0; err_first = 0;

    for (int i = 0; i < 10; i++) begin
      b_ce = tbl_b[i].ce; b_st = tbl_b[i].st; b_d = tbl_b[i].d;
      b_ef = tbl_b[i].ef; b_e = tbl_b[i].e;
      @(posedge clk); #1;
      chk("tblB valid", b_vo, tbl_b[i].v);
      chk("tblB first", b_fo, tbl_b[i].f);
      chk("tblB last", b_lo, tbl_b[i].l);
      chk("tblB data", b_do, tbl_b[i].dout);
      chk("tblB pending", b_pend, tbl_b[i].pend);
    end

    // Fill to capacity, overflow, then back-to-back replay with concurrent writes.
    do_reset();
    for (int c = 0; c < 4; c++)
      for (int b = 0; b < NB; b++) mcyc(1, b == 0, 1'($urandom), 0, 0);
    chk("full pending", pending, 4);
    for (int b = 0; b < NB; b++) mcyc(1, b == 0, 1'($urandom), 0, 0);
    chk("overflow set", overflow, 1);
    chk("overflow pending", pending, 4);
    for (int i = 0; i < 34; i++) begin
      mcyc((i >= 4 && i <= 8) || (i >= 10 && i <= 14), i == 4 || i == 10, 1'($urandom),
           (i % 5 == 0) && i < 30, 1'($urandom));
      if (i == 4) chk("freed slot reused", pending, 3);
      if (i == 14) chk("write+read same cycle", pending, 3);
    end
    chk("drained", pending, 0);

    // Underflow and its clearing by reset.
    do_reset();
    mcyc(0, 0, 0, 1, 1);
    chk("underflow set", underflow, 1);
    for (int i = 0; i < 4; i++) mcyc(0, 0, 0, 0, 1);
    do_reset();
    chk("underflow cleared", underflow, 0);

    // Restart in the middle of a fill.
    mcyc(1, 1, 1, 0, 0);
    mcyc(1, 0, 1, 0, 0);
    mcyc(1, 1, 0, 0, 0);
    mcyc(1, 0, 1, 0, 0);
    mcyc(1, 0, 1, 0, 0);
    mcyc(1, 0, 0, 0, 0);
    mcyc(1, 0, 1, 0, 0);
    chk("restart pending", pending, 1);
    mcyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) mcyc(0, 0, 0, 0, 0);

    // Asynchronous reset during replay.
    for (int b = 0; b < NB; b++) mcyc(1, b == 0, 1, 0, 0);
    mcyc(0, 0, 0, 1, 0);
    mcyc(0, 0, 0, 0, 0);
    mcyc(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", valid_out, 0);
    chk("async rst data", data_out, 0);
    chk("async rst pending", pending, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic ce, st, ef;
      if (i % 800 == 799) do_reset();
      ce = $urandom_range(0, 9) < 7;
      st = ce && ($urandom_range(0, 7) == 0);
      ef = $urandom_range(0, 7) == 0;
      mcyc(ce, st, 1'($urandom), ef, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
